mul_share_arb: RTL and testbench

- Shares one pipelined 32-bit low-product multiply cell between NUM_REQ independent requesters.
- Each cycle, a round-robin arbiter grants at most one request. The grant's operands are registered and driven to the cell. An ID tag travels alongside the operation and steers the product back to the owning requester as a one-cycle response pulse.
- Sits between the custom-instruction/accelerator masters and the shared multiply cell.

---
 rtl/mul_share_pkg.sv | 43 ++++
 rtl/mul_share_rr_arb.sv | 44 ++++
 rtl/mul_share_arb.sv | 112 +++++++++++
 tb/tb_mul_share_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_share_pkg : shared types and round-robin pick for mul_share_arb      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mul_share_pkg;

  localparam int MUL_DATA_W = 32;
  localparam int MAX_REQ    = 8;
  localparam int TAG_ID_W   = 3;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic                found;
    logic [TAG_ID_W-1:0] idx;
  } pick_t;

  // First set bit at or after ptr, wrapping modulo num.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [TAG_ID_W-1:0] ptr,
                                    input int num);
    pick_t res;
    int    cand;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < num && !res.found) begin
        cand = int'(ptr) + k;
        if (cand >= num) cand = cand - num;
        if (req[cand[TAG_ID_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[TAG_ID_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_share_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_share_rr_arb : round-robin pointer and one-hot grant                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mul_share_rr_arb
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  output logic                accept,
  output logic [TAG_ID_W-1:0] winner
);

  logic [TAG_ID_W-1:0] rr_ptr;
  logic [MAX_REQ-1:0]  req_ext;
  pick_t               pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_valid;
    pick                   = rr_pick(req_ext, rr_ptr, NUM_REQ);
    // Grant is suppressed while flushing and while reset is held.
    accept                 = pick.found & ~flush & reset_n;
    winner                 = pick.idx;
    req_ready              = '0;
    if (accept) req_ready  = NUM_REQ'(1) << pick.idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == TAG_ID_W'(NUM_REQ - 1)) ? '0 : winner + TAG_ID_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_share_arb : shares one pipelined 32-bit multiply cell between        |
// | NUM_REQ requesters; optional counters under MUL_SHARE_ARB_PERF_EN.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int ID_W        = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_src1,
  input  logic [NUM_REQ*32-1:0]      req_src2,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [MUL_DATA_W-1:0]      resp_data,
  output logic [MUL_DATA_W-1:0]      mul_src1,
  output logic [MUL_DATA_W-1:0]      mul_src2,
  input  logic [MUL_DATA_W-1:0]      mul_result
`ifdef MUL_SHARE_ARB_PERF_EN
  ,
  input  logic                       perf_clr,
  output logic [31:0]                perf_ops,
  output logic [31:0]                perf_stall
`endif
);

  localparam int STAGES = MUL_LATENCY + 1;

  logic                accept;
  logic [TAG_ID_W-1:0] winner;
  tag_t                tag_q [STAGES];
  logic [ID_W-1:0]     last_id;
  logic [NUM_REQ-1:0]  last_onehot;

  mul_share_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .accept    (accept),
    .winner    (winner)
  );

  always_comb begin
    last_id     = ID_W'(tag_q[STAGES-1].id);
    last_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      last_onehot[i] = (last_id == ID_W'(i));
    end
  end

  // Operands only move on accept so the cell inputs stay quiet when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_src1   <= '0;
      mul_src2   <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
    end else begin
      if (accept) begin
        mul_src1 <= req_src1[32*int'(winner) +: 32];
        mul_src2 <= req_src2[32*int'(winner) +: 32];
      end
      tag_q[0].vld <= accept;
      tag_q[0].id  <= winner;
      for (int s = 1; s < STAGES; s++) begin
        tag_q[s] <= flush ? '0 : tag_q[s-1];
      end
      if (!flush && tag_q[STAGES-1].vld) begin
        resp_data  <= mul_result;
        resp_valid <= last_onehot;
      end else begin
        resp_valid <= '0;
      end
    end
  end

`ifdef MUL_SHARE_ARB_PERF_EN
  logic stall_cycle;

  // A cycle stalls when someone is left waiting behind the winner or a flush.
  always_comb begin
    stall_cycle = flush ? (|req_valid) : ($countones(req_valid) > 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else if (perf_clr) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (accept && perf_ops != '1)        perf_ops   <= perf_ops + 32'd1;
      if (stall_cycle && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_share_arb : directed self-checking bench for mul_share_arb        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mul_share_arb;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_src1;
  logic [127:0] req_src2;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_data;
  logic [31:0]  mul_src1;
  logic [31:0]  mul_src2;
  logic [31:0]  mul_result = '0;
`ifdef MUL_SHARE_ARB_PERF_EN
  logic         perf_clr;
  logic [31:0]  perf_ops;
  logic [31:0]  perf_stall;
`endif

  logic [31:0]  a_lane [4];
  logic [31:0]  b_lane [4];
  logic [31:0]  rr_prod [4] = '{32'h0000_0030, 32'h0000_0033, 32'h0000_0036, 32'h0000_0039};

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_src1 = '0;
    req_src2 = '0;
    for (int i = 0; i < 4; i++) begin
      req_src1[32*i +: 32] = a_lane[i];
      req_src2[32*i +: 32] = b_lane[i];
    end
  end

  // One-edge multiply cell, low 32 bits only.
  always @(posedge clk) mul_result <= mul_src1 * mul_src2;

  mul_share_arb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_result (mul_result)
`ifdef MUL_SHARE_ARB_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in cycle 0, follow it to its response in cycle 3.
  task automatic single_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag);
    a_lane[idx] = a;
    b_lane[idx] = b;
    req_valid   = 4'(1 << idx);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = '0;
    check({tag, "_src1"}, mul_src1, a);
    check({tag, "_c1_idle"}, 32'(resp_valid), 32'h0);
    tick();
    check({tag, "_c2_idle"}, 32'(resp_valid), 32'h0);
    tick();
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'(1 << idx));
    check({tag, "_resp_data"}, resp_data, exp);
    tick();
    check({tag, "_pulse_end"}, 32'(resp_valid), 32'h0);
    check({tag, "_data_hold"}, resp_data, exp);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
`ifdef MUL_SHARE_ARB_PERF_EN
    perf_clr  = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      a_lane[i] = '0;
      b_lane[i] = '0;
    end
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_src1", mul_src1, 32'h0);
    check("rst_src2", mul_src2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // rr_ptr: 0 -> 3 after requester 2, then stays 0 after requester 3.
    single_op(2, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, "single");
    single_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "trunc_ff");
    single_op(3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "trunc_hi");

    for (int i = 0; i < 4; i++) begin
      a_lane[i] = 32'h10 + 32'(i);
      b_lane[i] = 32'h3;
    end
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 3) begin
        check("rr_resp_valid", 32'(resp_valid), 32'(1 << ((c - 3) % 4)));
        check("rr_resp_data", resp_data, rr_prod[(c - 3) % 4]);
      end else begin
        check("rr_early_idle", 32'(resp_valid), 32'h0);
      end
      tick();
    end
    req_valid = '0;

    // Flush: two ops in flight are dropped, pointer and operands hold.
    a_lane[1] = 32'd5; b_lane[1] = 32'd7;
    req_valid = 4'b0010;
    #1 check("fl_ready0", 32'(req_ready), 32'h2);
    tick();
    a_lane[2] = 32'd6; b_lane[2] = 32'd6;
    req_valid = 4'b0100;
    #1 check("fl_ready1", 32'(req_ready), 32'h4);
    tick();
    flush     = 1'b1;
    req_valid = 4'b1111;
    #1 check("fl_ready_blocked", 32'(req_ready), 32'h0);
    tick();
    flush = 1'b0;
    check("fl_c3_idle", 32'(resp_valid), 32'h0);
    check("fl_src1_hold", mul_src1, 32'd6);
    a_lane[3] = 32'd9; b_lane[3] = 32'd9;
    req_valid = 4'b1001;
    #1 check("fl_ptr_hold", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    check("fl_c4_idle", 32'(resp_valid), 32'h0);
    tick();
    check("fl_c5_idle", 32'(resp_valid), 32'h0);
    tick();
    check("fl_c6_valid", 32'(resp_valid), 32'h8);
    check("fl_c6_data", resp_data, 32'h0000_0051);
    tick();

    // Async reset with two ops in flight.
    a_lane[0] = 32'd2; b_lane[0] = 32'd3;
    req_valid = 4'b0001;
    tick();
    a_lane[1] = 32'd4; b_lane[1] = 32'd5;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1 reset_n = 1'b0;
    #1;
    check("ar_resp_valid", 32'(resp_valid), 32'h0);
    check("ar_resp_data", resp_data, 32'h0);
    check("ar_src1", mul_src1, 32'h0);
    check("ar_src2", mul_src2, 32'h0);
    check("ar_ready", 32'(req_ready), 32'h0);
    #2 reset_n = 1'b1;
    tick();
    for (int c = 3; c <= 5; c++) begin
      check("ar_no_pulse", 32'(resp_valid), 32'h0);
      tick();
    end
    a_lane[1] = 32'd7; b_lane[1] = 32'd8;
    a_lane[2] = 32'd1; b_lane[2] = 32'd1;
    req_valid = 4'b0110;
    #1 check("ar_ptr_zero", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    repeat (2) tick();
    check("ar_new_valid", 32'(resp_valid), 32'h2);
    check("ar_new_data", resp_data, 32'h0000_0038);
    tick();

`ifdef MUL_SHARE_ARB_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("pf_clr_ops", perf_ops, 32'h0);
    check("pf_clr_stall", perf_stall, 32'h0);
    req_valid = 4'b0111;
    repeat (4) tick();
    req_valid = '0;
    check("pf_ops", perf_ops, 32'd4);
    check("pf_stall", perf_stall, 32'd4);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("pf_clr2_ops", perf_ops, 32'h0);
    check("pf_clr2_stall", perf_stall, 32'h0);
    repeat (4) tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
